// File: rtl/mandel_view_loader.sv
// rtl/mandel_view_loader.sv - viewport shadow/active register loader with frame-boundary commit
module mandel_view_loader #(
    parameter int          BITS        = 16,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] DEF_X_LEFT  = 16'hA800,
    parameter logic [15:0] DEF_Y_TOP   = 16'h3400,
    parameter logic [15:0] DEF_X_INC   = 16'h010E,
    parameter logic [15:0] DEF_Y_INC   = 16'h0033
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      pin_data,
    input  logic [2:0]      pin_addr,
    input  logic            pin_strobe,
    input  logic            pin_commit,
    input  logic            frame_start,
    output logic [BITS-1:0] x_left,
    output logic [BITS-1:0] y_top,
    output logic [BITS-1:0] x_inc,
    output logic [BITS-1:0] y_inc,
    output logic            pending,
    output logic            applied
);

    localparam logic [4*BITS-1:0] DEF_ALL = {DEF_Y_INC, DEF_X_INC, DEF_Y_TOP, DEF_X_LEFT};

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] strobe_sync;
    logic [SYNC_STAGES-1:0] commit_sync;
    logic                   strobe_hist;
    logic                   commit_hist;
    logic                   strobe_edge;
    logic                   commit_edge;
    logic                   do_apply;
    logic [4*BITS-1:0]      shadow;
    logic [4*BITS-1:0]      active;

    // Synchronisers and edge history reset high so a pin held high through
    // reset release never looks like a fresh rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            strobe_sync <= '1;
            commit_sync <= '1;
            strobe_hist <= 1'b1;
            commit_hist <= 1'b1;
        end else begin
            strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], pin_strobe};
            commit_sync <= {commit_sync[SYNC_STAGES-2:0], pin_commit};
            strobe_hist <= strobe_sync[SYNC_STAGES-1];
            commit_hist <= commit_sync[SYNC_STAGES-1];
        end
    end

    assign strobe_edge = strobe_sync[SYNC_STAGES-1] & ~strobe_hist;
    assign commit_edge = commit_sync[SYNC_STAGES-1] & ~commit_hist;

    // Copy and byte write share an edge; nonblocking semantics make the copy
    // see the pre-write shadow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= DEF_ALL;
        end else if (strobe_edge) begin
            shadow[{pin_addr, 3'b000} +: 8] <= pin_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active  <= DEF_ALL;
            applied <= 1'b0;
            state   <= IDLE;
        end else begin
            applied <= do_apply;
            state   <= next_state;
            if (do_apply) begin
                active <= shadow;
            end
        end
    end

    always_comb begin
        next_state = state;
        do_apply   = 1'b0;
        case (state)
            IDLE: begin
                if (commit_edge) begin
                    next_state = PEND;
                end
            end
            PEND: begin
                if (frame_start) begin
                    do_apply   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign pending = (state == PEND);
    assign x_left  = active[BITS-1:0];
    assign y_top   = active[2*BITS-1:BITS];
    assign x_inc   = active[3*BITS-1:2*BITS];
    assign y_inc   = active[4*BITS-1:3*BITS];

endmodule

// File: tb/tb_mandel_view_loader.sv
// tb/tb_mandel_view_loader.sv - self-checking bench for mandel_view_loader
module tb_mandel_view_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pin_data = 8'h00;
    logic [2:0]  pin_addr = 3'd0;
    logic        pin_strobe = 1'b0;
    logic        pin_commit = 1'b0;
    logic        frame_start = 1'b0;
    logic [15:0] x_left, y_top, x_inc, y_inc;
    logic        pending, applied;

    int checks = 0;
    int failures = 0;
    int applied_count = 0;
    bit started = 1'b0;

    localparam logic [63:0] DEF_ALL = {16'h0033, 16'h010E, 16'h3400, 16'hA800};

    mandel_view_loader dut (
        .clk(clk), .rst_n(rst_n), .pin_data(pin_data), .pin_addr(pin_addr),
        .pin_strobe(pin_strobe), .pin_commit(pin_commit), .frame_start(frame_start),
        .x_left(x_left), .y_top(y_top), .x_inc(x_inc), .y_inc(y_inc),
        .pending(pending), .applied(applied)
    );

    always #5 clk = ~clk;

    // Model: a pin rise is acted on at the third clock edge that sees it high.
    logic [63:0] m_shadow, m_active;
    bit          m_pend, m_app;
    bit [2:0]    s_h, c_h;

    always @(posedge clk) begin
        bit wr, cm;
        if (!rst_n) begin
            m_shadow = DEF_ALL;
            m_active = DEF_ALL;
            m_pend   = 0;
            m_app    = 0;
            s_h      = 3'b111;
            c_h      = 3'b111;
            started  = 1'b1;
        end else begin
            wr    = s_h[1] & ~s_h[2];
            cm    = c_h[1] & ~c_h[2];
            m_app = 0;
            if (m_pend && frame_start) begin
                m_active = m_shadow;
                m_app    = 1;
                m_pend   = 0;
            end else if (!m_pend && cm) begin
                m_pend = 1;
            end
            if (wr) m_shadow[pin_addr*8 +: 8] = pin_data;
            s_h = {s_h[1:0], pin_strobe};
            c_h = {c_h[1:0], pin_commit};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model_outputs", {y_inc, x_inc, y_top, x_left}, m_active);
            chk("model_pending", {63'd0, pending}, {63'd0, m_pend});
            chk("model_applied", {63'd0, applied}, {63'd0, m_app});
            if (applied === 1'b1) applied_count++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        pin_addr = a;
        pin_data = d;
        wait_clk(1);
        pin_strobe = 1'b1;
        wait_clk(5);
        pin_strobe = 1'b0;
        wait_clk(4);
    endtask

    task automatic do_commit();
        @(negedge clk);
        pin_commit = 1'b1;
        wait_clk(4);
        pin_commit = 1'b0;
        wait_clk(4);
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    initial begin
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(1);
        chk("reset_values", {y_inc, x_inc, y_top, x_left}, 64'h0033_010E_3400_A800);
        chk("reset_pending", {63'd0, pending}, 64'd0);

        for (int i = 0; i < 100; i++) begin
            frame_pulse();
            wait_clk(2);
        end
        chk("idle_frames_no_apply", applied_count, 0);
        chk("idle_frames_values", {y_inc, x_inc, y_top, x_left}, 64'h0033_010E_3400_A800);

        write_byte(3'd4, 8'h20);
        write_byte(3'd5, 8'h02);
        do_commit();
        chk("pending_after_commit", {63'd0, pending}, 64'd1);
        frame_pulse();
        chk("x_inc_applied", {63'd0, applied}, 64'd1);
        chk("x_inc_value", {y_inc, x_inc, y_top, x_left}, 64'h0033_0220_3400_A800);
        wait_clk(1);
        chk("pending_cleared", {62'd0, pending, applied}, 64'd0);

        write_byte(3'd0, 8'h34);
        write_byte(3'd1, 8'h12);
        write_byte(3'd2, 8'h78);
        write_byte(3'd3, 8'h56);
        write_byte(3'd4, 8'hBC);
        write_byte(3'd5, 8'h9A);
        write_byte(3'd6, 8'hF0);
        write_byte(3'd7, 8'hDE);
        do_commit();
        wait_clk(1000);
        chk("hold_without_frame", {y_inc, x_inc, y_top, x_left}, 64'h0033_0220_3400_A800);
        chk("hold_pending", {63'd0, pending}, 64'd1);
        frame_pulse();
        chk("all_four_applied", {y_inc, x_inc, y_top, x_left}, 64'hDEF0_9ABC_5678_1234);

        // Commit edge lands on the same edge as frame_start while idle.
        write_byte(3'd6, 8'h11);
        @(negedge clk);
        pin_commit = 1'b1;
        wait_clk(2);
        frame_start = 1'b1;
        wait_clk(1);
        frame_start = 1'b0;
        chk("coincident_no_update", {y_inc, x_inc, y_top, x_left}, 64'hDEF0_9ABC_5678_1234);
        chk("coincident_pending", {62'd0, pending, applied}, 64'd2);
        wait_clk(3);
        pin_commit = 1'b0;
        wait_clk(4);
        frame_pulse();
        chk("coincident_next_frame", {y_inc, x_inc, y_top, x_left}, 64'hDE11_9ABC_5678_1234);

        // Pins held high across reset release.
        @(negedge clk);
        pin_addr = 3'd0;
        pin_data = 8'h11;
        pin_strobe = 1'b1;
        pin_commit = 1'b1;
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(10);
        chk("held_high_no_pending", {63'd0, pending}, 64'd0);
        pin_commit = 1'b0;
        pin_strobe = 1'b0;
        wait_clk(4);
        pin_addr = 3'd1;
        pin_data = 8'h22;
        wait_clk(1);
        pin_strobe = 1'b1;
        wait_clk(5);
        pin_strobe = 1'b0;
        wait_clk(4);
        do_commit();
        frame_pulse();
        chk("single_write_after_reset", {y_inc, x_inc, y_top, x_left}, 64'h0033_010E_3400_2200);

        // Write landing on the applying frame_start is excluded from the copy.
        do_commit();
        @(negedge clk);
        pin_addr = 3'd0;
        pin_data = 8'h55;
        wait_clk(1);
        pin_strobe = 1'b1;
        wait_clk(2);
        frame_start = 1'b1;
        wait_clk(1);
        frame_start = 1'b0;
        chk("write_vs_apply_old", {y_inc, x_inc, y_top, x_left}, 64'h0033_010E_3400_2200);
        chk("write_vs_apply_pulse", {63'd0, applied}, 64'd1);
        wait_clk(3);
        pin_strobe = 1'b0;
        wait_clk(4);
        do_commit();
        frame_pulse();
        chk("write_vs_apply_new", {y_inc, x_inc, y_top, x_left}, 64'h0033_010E_3400_2255);

        wait_clk(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
